n_bit_serial_sub: RTL
=====================

Name: n_bit_serial_sub

Overview:
- Bit-serial N-bit subtractor: computes a − b − bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation companion to the team's parallel ripple-carry adder.
- It is used where area matters more than latency, and for cross-checking adder results in self-test paths.
- It has a start/ready/done handshake so a controller can issue back-to-back operations.

Parameters:
- N, 8, operand width in bits (N ≥ 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled only when ready=1.
- a  input  N  minuend; captured on the accepting edge.
- b  input  N  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- ready  output  1  high when idle and able to accept start. Combinational decode of state.
- done  output  1  registered single-cycle pulse; diff and bout are valid from this cycle.
- diff  output  N  result (a − b − bin) mod 2^N.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=IDLE, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and bit counter all cleared.
  - rst has priority over every other input.
  - Reset mid-operation aborts the operation with no done pulse; ready=1 in the cycle after the reset edge.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1: load a_sh←a, b_sh←b, brw←bin, cnt←0, state→SHIFT.
  - diff and bout are not modified at load; they keep the previous result until this operation completes.
- SHIFT: ready=0. Each edge processes bit cnt:
  - d = a_sh[0] ^ b_sh[0] ^ brw.
  - brw ← (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - Result shift register takes d into its MSB and shifts right.
  - a_sh and b_sh shift right; cnt increments.
- SHIFT exit: on the edge processing bit N−1 (cnt=N−1):
  - Transfer the result register (including that bit) to diff; bout←new brw.
  - done←1, state→DONE.
- DONE:
  - ready=0, done=1 for exactly this one cycle.
  - Next edge: done←0, state→IDLE.
- Latency: start accepted at edge E0; the N processing edges are E1..EN; done is high between EN and EN+1; the next start can be accepted at EN+2. Throughput is one operation per N+2 cycles.
- start while ready=0 is ignored; it is not queued.
- a, b and bin may change freely after the accepting edge without affecting the result.
- cnt width is clog2(N) bits. Terminal compare is against N−1; no wrap-around beyond that.
- Equivalence: {bout, diff} equals the (N+1)-bit two's-complement value of a − b − bin; bout=1 means a negative result.

Test Plan:
- N=8, rst held 2 cycles, then released:
  - ready=1, done=0, diff=0x00, bout=0.
- a=0x5A, b=0x23, bin=0, start 1 cycle at edge E0:
  - ready=0 for E1..EN+1; done=1 exactly in the cycle after E8.
  - diff=0x37, bout=0.
- a=0x10, b=0x20, bin=1:
  - diff=0xEF, bout=1 (negative result).
- a=0x00, b=0x00, bin=1:
  - diff=0xFF, bout=1 (borrow ripples through all bits).
- a=0xFF, b=0xFF, bin=0:
  - diff=0x00, bout=0.
- Start ignored while busy:
  - Start a=0x05, b=0x01, then pulse start with a=0x99 at E3.
  - Exactly one done; diff=0x04.
  - a then changes at E2; result is unaffected.
- Reset mid-operation:
  - Assert rst at E4 of an operation: no done pulse, diff=0x00, bout=0, ready=1 after the reset edge.
- Back-to-back operations:
  - Second start at EN+2: accepted, correct result.
  - Previous diff is held until the second done.
- Randomised: 1000 random a, b, bin triples checked against the reference model {bout, diff} = a − b − bin.

Source files
------------

// File: rtl/n_bit_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : n_bit_serial_sub
// Description : Bit-serial N-bit subtractor. Computes a - b - bin one bit per
//               clock, LSB first, through a single full-subtractor cell and a
//               borrow flop. A start/ready/done handshake allows a controller
//               to issue back-to-back operations (one every N+2 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module n_bit_serial_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
);

    // Bit counter only needs to reach N-1; keep at least one bit for tiny N.
    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_sh_q,  a_sh_d;
    logic [N-1:0]     b_sh_q,  b_sh_d;
    logic [N-1:0]     res_q,   res_d;
    logic             brw_q,   brw_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [N-1:0]     diff_q,  diff_d;
    logic             bout_q,  bout_d;
    logic             done_q,  done_d;

    // Full-subtractor cell operating on the current LSBs of the operands.
    logic         w_a0;
    logic         w_b0;
    logic         w_d_bit;
    logic         w_brw_nxt;
    logic [N-1:0] w_res_shift;

    // Single full-subtractor cell and the result register's next shift value.
    always_comb begin
        w_a0        = a_sh_q[0];
        w_b0        = b_sh_q[0];
        w_d_bit     = w_a0 ^ w_b0 ^ brw_q;
        w_brw_nxt   = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & brw_q);
        // New difference bit enters at the MSB; after N shifts bit 0 lands at LSB.
        w_res_shift = {w_d_bit, res_q[N-1:1]};
    end

    // Next-state and datapath control: defaults hold every register.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Operands are captured here; diff/bout keep the last result.
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                a_sh_d = {1'b0, a_sh_q[N-1:1]};
                b_sh_d = {1'b0, b_sh_q[N-1:1]};
                res_d  = w_res_shift;
                brw_d  = w_brw_nxt;
                if (cnt_q == C_LAST_BIT) begin
                    // Publish the full result including the bit processed now.
                    diff_d  = w_res_shift;
                    bout_d  = w_brw_nxt;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    // Ready is a pure decode of the idle state.
    always_comb begin
        ready = (state_q == ST_IDLE);
        done  = done_q;
        diff  = diff_q;
        bout  = bout_q;
    end

endmodule
`default_nettype wire
